// File: rtl/adder_bist_pkg.sv
// rtl/adder_bist_pkg.sv - shared state encoding and width helpers for adder_bist
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Vector index width: a, b and cin concatenated
  function automatic int vec_width(input int width);
    return 2 * width + 1;
  endfunction

  // Error counter width: one bit wider than the vector index, so a full run never saturates
  function automatic int cnt_width(input int width);
    return 2 * width + 2;
  endfunction

endpackage

// File: rtl/adder_golden.sv
// rtl/adder_golden.sv - combinational reference model producing {cout,sum} of a + b + cin
module adder_golden #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   result
);

  // Zero-extend every operand to WIDTH+1 bits so the carry-out lands in the top bit
  always_comb begin
    result = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

endmodule

// File: rtl/adder_bist.sv
// rtl/adder_bist.sv - exhaustive BIST for a combinational adder (optional ADDER_BIST_STOP_ON_FAIL_EN)
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic [WIDTH-1:0]         a,
  output logic [WIDTH-1:0]         b,
  output logic                     cin,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [2*WIDTH+1:0]       err_count,
  output logic                     fail_valid,
  output logic [2*WIDTH:0]         fail_vec
);

  localparam int VW = vec_width(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  state_t          state_q;
  state_t          state_d;
  logic [VW-1:0]   vec_q;
  logic [CW-1:0]   err_q;
  logic            fail_valid_q;
  logic [VW-1:0]   fail_vec_q;

  logic [WIDTH:0]  golden;
  logic            last_vec;
  logic            mismatch;
  logic            clear_run;
  logic            finish;

  // vec is forced to zero whenever the FSM leaves RUN, so the operands are 0 outside a run
  assign a   = vec_q[WIDTH-1:0];
  assign b   = vec_q[2*WIDTH-1:WIDTH];
  assign cin = vec_q[2*WIDTH];

  adder_golden #(
    .WIDTH (WIDTH)
  ) u_golden (
    .a      (a),
    .b      (b),
    .cin    (cin),
    .result (golden)
  );

  assign last_vec = (vec_q == {VW{1'b1}});
  assign mismatch = (state_q == ST_RUN) && ({cout, sum} != golden);

  assign busy       = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign pass       = done && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN
  always_comb begin
    state_d   = state_q;
    clear_run = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RUN;
          clear_run = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
        if (mismatch || last_vec) begin
`else
        if (last_vec) begin
`endif
          state_d = ST_DONE;
          finish  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Vector counter and result registers; results are held untouched in DONE
  always_ff @(posedge clk) begin
    if (reset || clear_run) begin
      vec_q        <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else if (state_q == ST_RUN) begin
      if (mismatch) begin
        if (err_q != {CW{1'b1}}) begin
          err_q <= err_q + CW'(1);
        end
        if (!fail_valid_q) begin
          fail_valid_q <= 1'b1;
          fail_vec_q   <= vec_q;
        end
      end
      vec_q <= finish ? '0 : vec_q + VW'(1);
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// tb/tb_adder_bist.sv - scoreboard bench for adder_bist at WIDTH=1 and WIDTH=4
module tb_adder_bist;

`ifdef ADDER_BIST_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif

  typedef struct {
    int e0;
    int lat;
    int err;
    int fvalid;
    int fvec;
    int pass;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start1 = 1'b0;
  logic start4 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode1 = 0;
  int   mode4 = 0;

  exp_t q1[$];
  exp_t q4[$];

  always #5 clk = ~clk;

  // Cycle index: after posedge k the value is k
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=1 adder under test with selectable faults
  logic [0:0] a1, b1, s1;
  logic       cin1, c1, busy1, done1, pass1, fv1;
  logic [3:0] ec1;
  logic [2:0] fvec1;
  logic [1:0] add1;
  assign add1 = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
  always_comb begin
    s1 = add1[0];
    c1 = add1[1];
    if (mode1 == 1) s1 = 1'b0;
    if (mode1 == 2) c1 = ~add1[1];
  end

  adder_bist #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .a(a1), .b(b1), .cin(cin1), .sum(s1), .cout(c1),
    .busy(busy1), .done(done1), .pass(pass1),
    .err_count(ec1), .fail_valid(fv1), .fail_vec(fvec1)
  );

  // WIDTH=4 ripple adder under test with optional sum[3] stuck-at-0
  logic [3:0] a4, b4, s4;
  logic       cin4, c4, busy4, done4, pass4, fv4;
  logic [9:0] ec4;
  logic [8:0] fvec4;
  logic [4:0] add4;
  assign add4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
  always_comb begin
    s4 = add4[3:0];
    c4 = add4[4];
    if (mode4 == 1) s4[3] = 1'b0;
  end

  adder_bist #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .a(a4), .b(b4), .cin(cin4), .sum(s4), .cout(c4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(ec4), .fail_valid(fv4), .fail_vec(fvec4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for WIDTH=1: vector walk, pass gating, and scoreboard pop on done rising
  logic done1_d = 1'b0;
  int   k1 = 0;
  exp_t e1;
  always @(negedge clk) begin
    if (busy1) begin
      chk("w1_vector", {cin1, b1, a1}, k1);
      k1++;
    end else begin
      k1 = 0;
      chk("w1_idle_operands", {cin1, b1, a1}, 0);
    end
    if (!done1) chk("w1_pass_gated", pass1, 0);
    if (done1 && !done1_d) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL w1_unexpected_done: got done=1 expected no run pending (t=%0t)", $time);
      end else begin
        e1 = q1.pop_front();
        chk("w1_latency", cyc - e1.e0, e1.lat);
        chk("w1_err_count", ec1, e1.err);
        chk("w1_fail_valid", fv1, e1.fvalid);
        chk("w1_fail_vec", fvec1, e1.fvec);
        chk("w1_pass", pass1, e1.pass);
      end
    end
    done1_d = done1;
  end

  // Monitor for WIDTH=4
  logic done4_d = 1'b0;
  int   k4 = 0;
  exp_t e4;
  always @(negedge clk) begin
    if (busy4) begin
      chk("w4_vector", {cin4, b4, a4}, k4);
      k4++;
    end else begin
      k4 = 0;
    end
    if (done4 && !done4_d) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected_done: got done=1 expected no run pending (t=%0t)", $time);
      end else begin
        e4 = q4.pop_front();
        chk("w4_latency", cyc - e4.e0, e4.lat);
        chk("w4_err_count", ec4, e4.err);
        chk("w4_fail_valid", fv4, e4.fvalid);
        chk("w4_fail_vec", fvec4, e4.fvec);
        chk("w4_pass", pass4, e4.pass);
      end
    end
    done4_d = done4;
  end

  task automatic wait_done1(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done1) return;
    end
    checks++;
    errors++;
    $display("FAIL w1_timeout: got no done expected done within %0d cycles", bound);
  endtask

  task automatic wait_done4(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done4) return;
    end
    checks++;
    errors++;
    $display("FAIL w4_timeout: got no done expected done within %0d cycles", bound);
  endtask

  // Issue a start pulse on the WIDTH=1 DUT and queue its expected result
  task automatic kick1(input int mode, input int lat, input int err,
                       input int fvalid, input int fvec, input int pass);
    exp_t e;
    @(posedge clk);
    #1;
    mode1  = mode;
    start1 = 1'b1;
    e.e0 = cyc + 1; e.lat = lat; e.err = err;
    e.fvalid = fvalid; e.fvec = fvec; e.pass = pass;
    q1.push_back(e);
    @(posedge clk);
    #1;
    start1 = 1'b0;
  endtask

  task automatic kick4(input int mode, input int lat, input int err,
                       input int fvalid, input int fvec, input int pass);
    exp_t e;
    @(posedge clk);
    #1;
    mode4  = mode;
    start4 = 1'b1;
    e.e0 = cyc + 1; e.lat = lat; e.err = err;
    e.fvalid = fvalid; e.fvec = fvec; e.pass = pass;
    q4.push_back(e);
    @(posedge clk);
    #1;
    start4 = 1'b0;
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, busy1, 0);
    chk({tag, "_done"}, done1, 0);
    chk({tag, "_pass"}, pass1, 0);
    chk({tag, "_err_count"}, ec1, 0);
    chk({tag, "_fail_valid"}, fv1, 0);
    chk({tag, "_fail_vec"}, fvec1, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset1("rst1");
    chk("rst4_busy", busy4, 0);
    chk("rst4_err_count", ec4, 0);
    chk("rst4_operands", {cin4, b4, a4}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Correct full adder, sum stuck-at-0, cout inverted
    kick1(0, 8, 0, 0, 0, 1);
    wait_done1(40);
    kick1(1, SOF ? 2 : 8, SOF ? 1 : 4, 1, 1, 0);
    wait_done1(40);
    kick1(2, SOF ? 1 : 8, SOF ? 1 : 8, 1, 0, 0);
    wait_done1(40);

    // Start during RUN cycle 3 must be ignored
    kick1(0, 8, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_done1(40);

    // Reset sampled at the end of RUN cycle 4 abandons the run
    @(posedge clk);
    #1;
    mode1  = 0;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset1("midrst");
    kick1(0, 8, 0, 0, 0, 1);
    wait_done1(40);

    // Start coincident with reset: reset wins
    @(posedge clk);
    #1;
    reset  = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    start1 = 1'b0;
    @(negedge clk);
    chk_reset1("rststart");
    repeat (3) @(negedge clk);
    chk("w1_queue_drained", q1.size(), 0);

    // WIDTH=4: correct adder, then sum[3] stuck-at-0 (256 of 512 vectors have sum bit 3 set)
    kick4(0, 512, 0, 0, 0, 1);
    wait_done4(600);
    kick4(1, SOF ? 9 : 512, SOF ? 1 : 256, 1, 8, 0);
    wait_done4(600);
    repeat (3) @(negedge clk);
    chk("w4_queue_drained", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Self-checking response block for the adder datapath: exhaustively drives every {a, b, cin} combination into an adder under test.
- Samples that adder's cout/sum and checks them against a built-in golden sum.
- Counts mismatches, captures the first failing vector, and reports pass/fail.
- Used as on-chip BIST for the ripple-carry adder feeding the single-cycle ALU; the adder under test is purely combinational, so there is zero cycles of DUT latency.

Parameters:
- WIDTH, 1, operand width of the adder under test (1 = single full adder); legal range 1..8.
- NVEC, 2**(2*WIDTH+1), derived localparam (not overridable): number of test vectors.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a test run
- a  output  WIDTH  operand A to adder under test
- b  output  WIDTH  operand B to adder under test
- cin  output  1  carry-in to adder under test
- sum  input  WIDTH  sum from adder under test
- cout  input  1  carry-out from adder under test
- busy  output  1  high while vectors are being applied
- done  output  1  high from run completion until next accepted start or reset
- pass  output  1  valid when done; 1 iff err_count == 0
- err_count  output  2*WIDTH+2  mismatching vectors in current/last run; saturates at all-ones
- fail_valid  output  1  a failing vector has been captured this run
- fail_vec  output  2*WIDTH+1  index of first failing vector

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset: state=IDLE; vec=0; busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0; a=b=0, cin=0.
- Vector mapping (registered counter vec, 2*WIDTH+1 bits):
  - a=vec[WIDTH-1:0], b=vec[2*WIDTH-1:WIDTH], cin=vec[2*WIDTH].
  - a/b/cin are driven from registers only and are 0 outside RUN.
- Golden check: expected {cout,sum} = a + b + cin, computed at WIDTH+1 bits, zero-extended. mismatch = ({cout,sum} != expected), evaluated combinationally in RUN.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start, go to RUN; vec=0, err_count=0, fail_valid=0, fail_vec=0, pass=0.
  - RUN: busy=1. Vector k is presented during RUN cycle k, k=0..NVEC-1, and checked at the edge that ends that cycle.
    - On mismatch: err_count increments (saturating). If fail_valid=0, then fail_vec=vec and fail_valid=1.
    - When vec==NVEC-1: go to DONE, done=1, pass=(final err_count==0), vec cleared to 0. No wrap into a second pass.
    - Otherwise vec increments.
  - DONE: busy=0; results held stable. On start, restart exactly as from IDLE (clear results, done drops the same edge).
- Latency: start sampled at edge E0; done=1 visible after edge E0+NVEC (WIDTH=1: 8 cycles).
- start while in RUN: ignored, no restart, no effect on counters.
- start coincident with reset: reset wins.
- Reset mid-run: abandons the run; all outputs return to reset values at that edge.
- pass is meaningful only while done=1; it is 0 otherwise.

Optional Feature:
- Macro: ADDER_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch in RUN ends the run at that edge (go to DONE, done=1, pass=0, err_count=1, fail_vec captured).
- Undefined: all NVEC vectors are always applied and err_count is the full mismatch count.

Decomposition:
- Shared package adder_bist_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - width helper functions for vector and count widths.
- One sub-module is natural: adder_golden (combinational WIDTH-bit a+b+cin reference model producing {cout,sum}), instantiated once.
- FSM, vector counter and result registers stay in adder_bist.

Test Plan:
- WIDTH=1, correct full adder attached, pulse start → a/b/cin walk vectors 0..7 over 8 cycles; done=1 at E0+8; err_count=0, pass=1, fail_valid=0.
- WIDTH=1, sum stuck-at-0 → expected sum=1 at vectors 1,2,4,7; done at E0+8, err_count=4, fail_vec=3'b001, fail_valid=1, pass=0.
- WIDTH=1, cout inverted → every vector fails; err_count=8, fail_vec=0, pass=0.
- start pulsed again at RUN cycle 3, then reset asserted at RUN cycle 4 of a second run:
  - the mid-run start is ignored (done still at E0+8);
  - the reset returns all outputs to 0 and state to IDLE;
  - a new start then gives a clean 8-cycle run.
- WIDTH=4 with a correct 4-bit ripple adder → 512 vectors, done at E0+512, err_count=0.
- WIDTH=4 with bit 3 of the adder's sum stuck-at-0 → first failure at fail_vec=8 (a=8, b=0, cin=0), pass=0.
- With ADDER_BIST_STOP_ON_FAIL_EN defined, WIDTH=1, sum stuck-at-0 → done at E0+2 (after vector 1), err_count=1, fail_vec=1.
- With ADDER_BIST_STOP_ON_FAIL_EN defined, WIDTH=1, correct adder → behaviour identical to the first scenario.
